// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter driving the select lines of an 8:1 mux
// with one-hot grant, valid flag and a bounded hold time per grant.
module mux8_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d, sel_q, sel_d, nxt;
  logic [7:0] cnt_q, cnt_d, gnt_q, gnt_d;
  logic [3:0] all_w, oth_w;
  logic       in_g, exp_w, go, keep;
  // {found, index} of the first set bit of r searching from p upward, mod 8
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] k;
    pick = '0;
    for (int i = 7; i >= 0; i--) begin
      k = p + 3'(i);
      if (r[k]) pick = {1'b1, k};
    end
  endfunction
  always_comb begin
    in_g    = state_q == GRANT;
    exp_w   = cnt_q == 8'(HOLD_MAX);
    all_w   = pick(req, ptr_q);
    oth_w   = pick(req & ~gnt_q, ptr_q);
    go      = en && (in_g ? oth_w[3] && (!req[sel_q] || exp_w) : all_w[3]);
    nxt     = in_g ? oth_w[2:0] : all_w[2:0];
    keep    = en && in_g && req[sel_q];
    state_d = (go || keep) ? GRANT : IDLE;
    sel_d   = go ? nxt : sel_q;
    gnt_d   = go ? 8'(1) << nxt : keep ? gnt_q : '0;
    ptr_d   = go ? nxt + 3'd1 : ptr_q;
    cnt_d   = go ? 8'd1 : keep ? (exp_w ? 8'd1 : cnt_q + 8'd1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end
  assign sel   = sel_q;
  assign gnt   = gnt_q;
  assign valid = state_q == GRANT;
endmodule
